ahb_bus_arbiter: RTL and testbench

- Two-master to one-slave AHB-Lite arbiter. Masters are the instruction-fetch port (I) and the LSU data port (D); the slave is the shared memory/bus fabric.
- D has fixed priority, with a starvation limit that guarantees I a slot.
- A master that loses arbitration while finishing its own data phase has its read data held, and its HREADY stretched, until its next address is accepted. This keeps both masters AHB-Lite compliant.
- Sits between the fetch unit / EX-stage LSU and the memory subsystem.

---
 rtl/ahb_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// Two-master (I-fetch, LSU) to one-slave AHB-Lite arbiter.
// D wins by default; a streak limit guarantees I a slot.
module ahb_bus_arbiter #(
    parameter int D_STREAK_MAX = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] i_haddr,
    input  logic [1:0]    i_htrans,
    input  logic          i_hwrite,
    input  logic [2:0]    i_hsize,
    input  logic [2:0]    i_hburst,
    input  logic [3:0]    i_hprot,
    input  logic [DW-1:0] i_hwdata,
    output logic [DW-1:0] i_hrdata,
    output logic          i_hready,

    input  logic [AW-1:0] d_haddr,
    input  logic [1:0]    d_htrans,
    input  logic          d_hwrite,
    input  logic [2:0]    d_hsize,
    input  logic [2:0]    d_hburst,
    input  logic [3:0]    d_hprot,
    input  logic [DW-1:0] d_hwdata,
    output logic [DW-1:0] d_hrdata,
    output logic          d_hready,

    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [2:0]    s_hburst,
    output logic [3:0]    s_hprot,
    output logic [DW-1:0] s_hwdata,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hready,

    output logic          grant_d
);

    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic          req_i;
    logic          req_d;
    logic          gnt_i;
    logic          gnt_d;
    logic          acc_i;
    logic          acc_d;
    logic          own_i;
    logic          own_d;
    logic          lose_i;
    logic          lose_d;

    logic          dp_valid;
    logic          dp_own;
    logic          hold_i;
    logic          hold_d;
    logic [DW-1:0] hold_data_i;
    logic [DW-1:0] hold_data_d;
    logic [SW-1:0] streak;

    assign req_i = i_htrans[1];
    assign req_d = d_htrans[1];

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (req_i && req_d) begin
                gnt_d = (streak < STREAK_MAX);
                gnt_i = !gnt_d;
            end else begin
                gnt_d = req_d;
                gnt_i = req_i;
            end
        end
    end

    assign acc_i   = gnt_i && s_hready;
    assign acc_d   = gnt_d && s_hready;
    assign grant_d = gnt_d;

    // Idle bus still presents D's address-phase fields.
    always_comb begin
        s_haddr  = d_haddr;
        s_hwrite = d_hwrite;
        s_hsize  = d_hsize;
        s_hburst = d_hburst;
        s_hprot  = d_hprot;
        s_htrans = HTRANS_IDLE;
        if (gnt_i) begin
            s_haddr  = i_haddr;
            s_hwrite = i_hwrite;
            s_hsize  = i_hsize;
            s_hburst = i_hburst;
            s_hprot  = i_hprot;
            s_htrans = i_htrans;
        end else if (gnt_d) begin
            s_htrans = d_htrans;
        end
    end

    assign s_hwdata = (dp_own == OWN_D) ? d_hwdata : i_hwdata;

    assign own_i  = dp_valid && (dp_own == OWN_I);
    assign own_d  = dp_valid && (dp_own == OWN_D);
    // Owner of the live data phase is asking again but lost the bus.
    assign lose_i = own_i && req_i && !gnt_i;
    assign lose_d = own_d && req_d && !gnt_d;

    always_comb begin
        i_hready = 1'b1;
        if (rst) begin
            i_hready = 1'b1;
        end else if (hold_i) begin
            i_hready = acc_i;
        end else if (lose_i) begin
            i_hready = 1'b0;
        end else if (own_i) begin
            i_hready = s_hready;
        end else if (req_i) begin
            i_hready = acc_i;
        end
    end

    always_comb begin
        d_hready = 1'b1;
        if (rst) begin
            d_hready = 1'b1;
        end else if (hold_d) begin
            d_hready = acc_d;
        end else if (lose_d) begin
            d_hready = 1'b0;
        end else if (own_d) begin
            d_hready = s_hready;
        end else if (req_d) begin
            d_hready = acc_d;
        end
    end

    assign i_hrdata = hold_i ? hold_data_i : s_hrdata;
    assign d_hrdata = hold_d ? hold_data_d : s_hrdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_own   <= OWN_D;
        end else if (s_hready) begin
            dp_valid <= acc_i || acc_d;
            dp_own   <= gnt_i ? OWN_I : OWN_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_i      <= 1'b0;
            hold_data_i <= '0;
        end else if (acc_i) begin
            hold_i      <= 1'b0;
        end else if (!hold_i && lose_i && s_hready) begin
            hold_i      <= 1'b1;
            hold_data_i <= s_hrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_d      <= 1'b0;
            hold_data_d <= '0;
        end else if (acc_d) begin
            hold_d      <= 1'b0;
        end else if (!hold_d && lose_d && s_hready) begin
            hold_d      <= 1'b1;
            hold_data_d <= s_hrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (!req_i || acc_i) begin
            streak <= '0;
        end else if (acc_d && (streak < STREAK_MAX)) begin
            streak <= streak + SW'(1);
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: vector table,
// directed multi-cycle sequences and a randomized model run.
module tb_ahb_bus_arbiter;

    localparam int MAX = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_haddr, d_haddr, s_haddr;
    logic [1:0]    i_htrans, d_htrans, s_htrans;
    logic          i_hwrite, d_hwrite, s_hwrite;
    logic [2:0]    i_hsize, d_hsize, s_hsize;
    logic [2:0]    i_hburst, d_hburst, s_hburst;
    logic [3:0]    i_hprot, d_hprot, s_hprot;
    logic [DW-1:0] i_hwdata, d_hwdata, s_hwdata;
    logic [DW-1:0] i_hrdata, d_hrdata, s_hrdata;
    logic          i_hready, d_hready, s_hready;
    logic          grant_d;

    ahb_bus_arbiter #(.D_STREAK_MAX(MAX), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_haddr(i_haddr), .i_htrans(i_htrans), .i_hwrite(i_hwrite),
        .i_hsize(i_hsize), .i_hburst(i_hburst), .i_hprot(i_hprot),
        .i_hwdata(i_hwdata), .i_hrdata(i_hrdata), .i_hready(i_hready),
        .d_haddr(d_haddr), .d_htrans(d_htrans), .d_hwrite(d_hwrite),
        .d_hsize(d_hsize), .d_hburst(d_hburst), .d_hprot(d_hprot),
        .d_hwdata(d_hwdata), .d_hrdata(d_hrdata), .d_hready(d_hready),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot),
        .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
        .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  i_tr;
        logic [1:0]  d_tr;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] d_addr;
        logic        e_gd;
        logic [1:0]  e_tr;
        logic [31:0] e_addr;
        logic        e_ir;
        logic        e_dr;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl[10];

    // Reference model state, indexed by master: 0 = I, 1 = D.
    int          m_streak;
    int          m_own;
    bit          m_valid;
    bit          m_held[2];
    logic [31:0] m_hdata[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_haddr = '0; i_htrans = 2'b00; i_hwrite = 1'b0;
        i_hsize = 3'd2; i_hburst = 3'd0; i_hprot = 4'h3; i_hwdata = '0;
        d_haddr = '0; d_htrans = 2'b00; d_hwrite = 1'b0;
        d_hsize = 3'd2; d_hburst = 3'd0; d_hprot = 4'h3; d_hwdata = '0;
        s_hready = 1'b1; s_hrdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_cycle(input int k);
        bit          rq[2];
        int          win;
        bit          acc[2];
        bit          lose[2];
        bit          mine;
        logic        er;
        logic [31:0] erd;
        logic [31:0] e_addr;
        logic [10:0] e_ctl;
        logic [1:0]  e_tr;
        rq[0] = i_htrans[1];
        rq[1] = d_htrans[1];
        if (rq[0] && rq[1]) win = (m_streak >= MAX) ? 0 : 1;
        else if (rq[1])     win = 1;
        else if (rq[0])     win = 0;
        else                win = -1;
        e_tr   = (win == 0) ? i_htrans : (win == 1) ? d_htrans : 2'b00;
        e_addr = (win == 0) ? i_haddr : d_haddr;
        e_ctl  = (win == 0) ? {i_hwrite, i_hsize, i_hburst, i_hprot}
                            : {d_hwrite, d_hsize, d_hburst, d_hprot};
        chk($sformatf("rnd%0d_htrans", k), 32'(s_htrans), 32'(e_tr));
        chk($sformatf("rnd%0d_haddr", k), s_haddr, e_addr);
        chk($sformatf("rnd%0d_ctl", k),
            32'({s_hwrite, s_hsize, s_hburst, s_hprot}), 32'(e_ctl));
        chk($sformatf("rnd%0d_hwdata", k), s_hwdata,
            (m_own == 1) ? d_hwdata : i_hwdata);
        chk($sformatf("rnd%0d_grant_d", k), 32'(grant_d), 32'(win == 1));
        for (int m = 0; m < 2; m++) begin
            acc[m]  = (win == m) && s_hready;
            mine    = m_valid && (m_own == m);
            lose[m] = !m_held[m] && mine && rq[m] && (win != m);
            if (m_held[m])  er = acc[m];
            else if (lose[m]) er = 1'b0;
            else if (mine)  er = s_hready;
            else if (rq[m]) er = acc[m];
            else            er = 1'b1;
            erd = m_held[m] ? m_hdata[m] : s_hrdata;
            chk($sformatf("rnd%0d_m%0d_hready", k, m),
                32'((m == 0) ? i_hready : d_hready), 32'(er));
            chk($sformatf("rnd%0d_m%0d_hrdata", k, m),
                (m == 0) ? i_hrdata : d_hrdata, erd);
        end
        for (int m = 0; m < 2; m++) begin
            if (acc[m]) begin
                m_held[m] = 1'b0;
            end else if (lose[m] && s_hready) begin
                m_held[m]  = 1'b1;
                m_hdata[m] = s_hrdata;
            end
        end
        if (s_hready) begin
            m_valid = (win >= 0);
            m_own   = (win == 0) ? 0 : 1;
        end
        if (!rq[0] || acc[0]) m_streak = 0;
        else if (acc[1] && m_streak < MAX) m_streak++;
    endtask

    initial begin
        tbl[0] = '{2'b00, 2'b00, 1'b1, 32'hAAAA0000, 32'h000,
                   1'b0, 2'b00, 32'h000, 1'b1, 1'b1, 32'hAAAA0000};
        tbl[1] = '{2'b00, 2'b10, 1'b1, 32'h11110000, 32'h100,
                   1'b1, 2'b10, 32'h100, 1'b1, 1'b1, 32'h11110000};
        tbl[2] = '{2'b00, 2'b10, 1'b1, 32'hD0000100, 32'h104,
                   1'b1, 2'b10, 32'h104, 1'b1, 1'b1, 32'hD0000100};
        tbl[3] = '{2'b00, 2'b10, 1'b1, 32'hD0000104, 32'h108,
                   1'b1, 2'b10, 32'h108, 1'b1, 1'b1, 32'hD0000104};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 32'hD0000108, 32'h108,
                   1'b0, 2'b00, 32'h108, 1'b1, 1'b1, 32'hD0000108};
        tbl[5] = '{2'b10, 2'b00, 1'b1, 32'h55550000, 32'h000,
                   1'b0, 2'b10, 32'h800, 1'b1, 1'b1, 32'h55550000};
        tbl[6] = '{2'b00, 2'b00, 1'b1, 32'h66660000, 32'h000,
                   1'b0, 2'b00, 32'h000, 1'b1, 1'b1, 32'h66660000};
        tbl[7] = '{2'b10, 2'b00, 1'b0, 32'h77770000, 32'h000,
                   1'b0, 2'b10, 32'h800, 1'b0, 1'b1, 32'h77770000};
        tbl[8] = '{2'b10, 2'b00, 1'b1, 32'h88880000, 32'h000,
                   1'b0, 2'b10, 32'h800, 1'b1, 1'b1, 32'h88880000};
        tbl[9] = '{2'b00, 2'b00, 1'b1, 32'h99990000, 32'h000,
                   1'b0, 2'b00, 32'h000, 1'b1, 1'b1, 32'h99990000};

        // Reset state, with both masters already requesting.
        idle_inputs();
        i_htrans = 2'b10;
        d_htrans = 2'b10;
        s_hrdata = 32'h5A5A5A5A;
        @(negedge clk);
        #1;
        chk("rst_htrans", 32'(s_htrans), 32'h0);
        chk("rst_grant_d", 32'(grant_d), 32'h0);
        chk("rst_i_hready", 32'(i_hready), 32'h1);
        chk("rst_d_hready", 32'(d_hready), 32'h1);
        chk("rst_i_hrdata", i_hrdata, 32'h5A5A5A5A);
        chk("rst_d_hrdata", d_hrdata, 32'h5A5A5A5A);

        // Vector table: D back-to-back reads, idle, single I request.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_htrans = tbl[k].i_tr;
            i_haddr  = 32'h800;
            d_htrans = tbl[k].d_tr;
            d_haddr  = tbl[k].d_addr;
            s_hready = tbl[k].rdy;
            s_hrdata = tbl[k].rdata;
            #1;
            chk($sformatf("tbl%0d_grant_d", k), 32'(grant_d), 32'(tbl[k].e_gd));
            chk($sformatf("tbl%0d_htrans", k), 32'(s_htrans), 32'(tbl[k].e_tr));
            chk($sformatf("tbl%0d_haddr", k), s_haddr, tbl[k].e_addr);
            chk($sformatf("tbl%0d_i_hready", k), 32'(i_hready), 32'(tbl[k].e_ir));
            chk($sformatf("tbl%0d_d_hready", k), 32'(d_hready), 32'(tbl[k].e_dr));
            chk($sformatf("tbl%0d_d_hrdata", k), d_hrdata, tbl[k].e_drd);
        end

        // Continuous contention: D,D,D,D,I,D,D,D,D,I plus hold handoff.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_htrans = 2'b10;
            d_htrans = 2'b10;
            s_hready = 1'b1;
            s_hrdata = 32'hC0DE0000 + 32'(c);
            #1;
            chk($sformatf("streak%0d_grant_d", c), 32'(grant_d),
                32'(!(c == 4 || c == 9)));
            if (c == 4) chk("streak_d_lose_hready", 32'(d_hready), 32'h0);
            if (c == 5) begin
                chk("streak_d_hold_hready", 32'(d_hready), 32'h1);
                chk("streak_d_hold_data", d_hrdata, 32'hC0DE0004);
                chk("streak_i_lose_hready", 32'(i_hready), 32'h0);
            end
            if (c == 9) begin
                chk("streak_i_hold_hready", 32'(i_hready), 32'h1);
                chk("streak_i_hold_data", i_hrdata, 32'hC0DE0005);
            end
        end

        // I read data held across a lost arbitration.
        do_reset();
        @(negedge clk);
        i_htrans = 2'b10; i_haddr = 32'h200;
        #1;
        chk("ihold_acc_hready", 32'(i_hready), 32'h1);
        @(negedge clk);
        i_haddr = 32'h204;
        d_htrans = 2'b10; d_haddr = 32'h400;
        s_hrdata = 32'hDEADBEEF;
        #1;
        chk("ihold_gd", 32'(grant_d), 32'h1);
        chk("ihold_lose_hready", 32'(i_hready), 32'h0);
        @(negedge clk);
        d_htrans = 2'b00;
        s_hrdata = 32'h0BAD0BAD;
        #1;
        chk("ihold_haddr", s_haddr, 32'h204);
        chk("ihold_hready", 32'(i_hready), 32'h1);
        chk("ihold_hrdata", i_hrdata, 32'hDEADBEEF);
        chk("ihold_d_hrdata", d_hrdata, 32'h0BAD0BAD);
        @(negedge clk);
        i_htrans = 2'b00;
        s_hrdata = 32'h13572468;
        #1;
        chk("ihold_clr_hrdata", i_hrdata, 32'h13572468);
        chk("ihold_clr_hready", 32'(i_hready), 32'h1);

        // D write stretched by two wait states, I stalled behind it.
        do_reset();
        @(negedge clk);
        d_htrans = 2'b10; d_haddr = 32'h300; d_hwrite = 1'b1;
        #1;
        chk("wr_hwrite", 32'(s_hwrite), 32'h1);
        chk("wr_acc_hready", 32'(d_hready), 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            d_htrans = 2'b00; d_hwrite = 1'b0;
            d_hwdata = 32'h12345678;
            i_htrans = 2'b10; i_haddr = 32'h500;
            s_hready = (c == 2);
            #1;
            chk($sformatf("wr%0d_hwdata", c), s_hwdata, 32'h12345678);
            chk($sformatf("wr%0d_d_hready", c), 32'(d_hready), 32'(c == 2));
            chk($sformatf("wr%0d_i_hready", c), 32'(i_hready), 32'(c == 2));
            chk($sformatf("wr%0d_haddr", c), s_haddr, 32'h500);
        end

        // Asynchronous reset in the middle of a stalled transfer.
        do_reset();
        @(negedge clk);
        i_htrans = 2'b10; i_haddr = 32'h200;
        @(negedge clk);
        d_htrans = 2'b10; d_haddr = 32'h400;
        s_hrdata = 32'h00000077;
        @(negedge clk);
        s_hready = 1'b0;
        #1;
        chk("arst_pre_d_hready", 32'(d_hready), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_htrans", 32'(s_htrans), 32'h0);
        chk("arst_i_hready", 32'(i_hready), 32'h1);
        chk("arst_d_hready", 32'(d_hready), 32'h1);
        chk("arst_grant_d", 32'(grant_d), 32'h0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b0;
            s_hready = 1'b1;
            s_hrdata = 32'h99 + 32'(c);
            #1;
            chk($sformatf("arst%0d_grant_d", c), 32'(grant_d), 32'(c != 4));
            if (c == 0) chk("arst_i_hrdata", i_hrdata, 32'h99);
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_streak = 0; m_own = 1; m_valid = 1'b0;
        m_held[0] = 1'b0; m_held[1] = 1'b0;
        m_hdata[0] = '0; m_hdata[1] = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            i_htrans = 2'($urandom_range(0, 3));
            d_htrans = 2'($urandom_range(0, 3));
            i_haddr  = $urandom;
            d_haddr  = $urandom;
            i_hwrite = 1'($urandom);
            d_hwrite = 1'($urandom);
            i_hsize  = 3'($urandom);
            d_hsize  = 3'($urandom);
            i_hburst = 3'($urandom);
            d_hburst = 3'($urandom);
            i_hprot  = 4'($urandom);
            d_hprot  = 4'($urandom);
            i_hwdata = $urandom;
            d_hwdata = $urandom;
            s_hready = ($urandom_range(0, 3) != 0);
            s_hrdata = $urandom;
            #1;
            model_cycle(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
